video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running x/y counters, sync/blanking decode and
// a delay line that keeps hsync/vsync/de aligned with the registered colour.
module video_timing_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int SYNC_POL   = 0,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so H_TOTAL=2048 / V_TOTAL=1024 boundaries compare cleanly.
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = !SYNC_ON;

  logic [10:0] x_reg, x_next;
  logic [9:0]  y_reg, y_next;
  logic [11:0] x_ext;
  logic [10:0] y_ext;

  assign x_ext = {1'b0, x_reg};
  assign y_ext = {1'b0, y_reg};

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (pix_en) begin
      if (x_ext == H_LAST) begin
        x_next = '0;
        if (y_ext == V_LAST) begin
          y_next = '0;
        end else begin
          y_next = y_reg + 10'd1;
        end
      end else begin
        x_next = x_reg + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      x_reg <= x_next;
      y_reg <= y_next;
    end
  end

  assign frame_start = pix_en && (x_reg == 11'd0) && (y_reg == 10'd0);

  logic de_raw, hs_raw, vs_raw;

  assign de_raw = (x_ext < H_ACT) && (y_ext < V_ACT);
  assign hs_raw = ((x_ext >= HS_BEG) && (x_ext < HS_END)) ? SYNC_ON : SYNC_OFF;
  assign vs_raw = ((y_ext >= VS_BEG) && (y_ext < VS_END)) ? SYNC_ON : SYNC_OFF;

  // Stage 0 captures the raw decode; stage PIPE_DELAY-1 drives the outputs.
  logic de_pipe [PIPE_DELAY];
  logic hs_pipe [PIPE_DELAY];
  logic vs_pipe [PIPE_DELAY];

  for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
    logic de_src, hs_src, vs_src;

    if (gi == 0) begin : g_head
      assign de_src = de_raw;
      assign hs_src = hs_raw;
      assign vs_src = vs_raw;
    end else begin : g_tail
      assign de_src = de_pipe[gi-1];
      assign hs_src = hs_pipe[gi-1];
      assign vs_src = vs_pipe[gi-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        de_pipe[gi] <= 1'b0;
        hs_pipe[gi] <= SYNC_OFF;
        vs_pipe[gi] <= SYNC_OFF;
      end else if (pix_en) begin
        de_pipe[gi] <= de_src;
        hs_pipe[gi] <= hs_src;
        vs_pipe[gi] <= vs_src;
      end
    end
  end

  // de of the pixel whose colour is on r_in/g_in/b_in right now; it lands in
  // the last stage on the same edge the colour is registered.
  logic de_pre;

  if (PIPE_DELAY == 1) begin : g_pre_raw
    assign de_pre = de_raw;
  end else begin : g_pre_pipe
    assign de_pre = de_pipe[PIPE_DELAY-2];
  end

  logic [7:0] rgb_in  [3];
  logic [7:0] rgb_reg [3];

  assign rgb_in[0] = r_in;
  assign rgb_in[1] = g_in;
  assign rgb_in[2] = b_in;

  for (genvar gi = 0; gi < 3; gi++) begin : g_colour
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rgb_reg[gi] <= '0;
      end else if (pix_en) begin
        rgb_reg[gi] <= de_pre ? rgb_in[gi] : 8'h00;
      end
    end
  end

  assign x     = x_reg;
  assign y     = y_reg;
  assign hsync = hs_pipe[PIPE_DELAY-1];
  assign vsync = vs_pipe[PIPE_DELAY-1];
  assign de    = de_pipe[PIPE_DELAY-1];
  assign r     = rgb_reg[0];
  assign g     = rgb_reg[1];
  assign b     = rgb_reg[2];

endmodule
